// File: rtl/ifu_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_e;

    localparam logic [31:0] IFU_RST_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: request, wait for response,
// hold the word for the decoder; EXU redirects kill or drop in-flight fetches.
module ifu_fetch_ctrl
    import ifu_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RST_PC     = ADDR_WIDTH'(IFU_RST_PC)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_exu_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
    input  logic                  i_mem_rsp_err,
    output logic                  o_ifu_valid,
    input  logic                  i_idu_ready,
    output logic [ADDR_WIDTH-1:0] o_ifu_pc,
    output logic [DATA_WIDTH-1:0] o_ifu_inst,
    output logic                  o_ifu_err
);

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q,    pc_d;
    logic                  drop_q,  drop_d;
    logic [DATA_WIDTH-1:0] inst_q,  inst_d;
    logic                  err_q,   err_d;

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RST_PC;
            drop_q  <= 1'b0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        err_d   = err_q;
        case (state_q)
            S_REQ: begin
                if (i_exu_jmp_en) begin
                    pc_d = i_exu_jmp_pc;
                end
                // A redirect accepted alongside the request leaves a stale fetch in flight.
                if (i_mem_req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = i_exu_jmp_en;
                end
            end
            S_WAIT: begin
                if (i_mem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (i_exu_jmp_en) begin
                        pc_d    = i_exu_jmp_pc;
                        state_d = S_REQ;
                    end else if (drop_q) begin
                        state_d = S_REQ;
                    end else begin
                        inst_d  = i_mem_rsp_data;
                        err_d   = i_mem_rsp_err;
                        state_d = S_OUT;
                    end
                end else if (i_exu_jmp_en) begin
                    pc_d   = i_exu_jmp_pc;
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (i_exu_jmp_en) begin
                    pc_d    = i_exu_jmp_pc;
                    state_d = S_REQ;
                end else if (i_idu_ready) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_comb begin
        o_mem_req_valid = (state_q == S_REQ);
        o_ifu_valid     = (state_q == S_OUT) && !i_exu_jmp_en;
    end

    assign o_mem_req_addr = pc_q;
    assign o_ifu_pc       = pc_q;
    assign o_ifu_inst     = inst_q;
    assign o_ifu_err      = err_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a transaction-level reference model.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jmp_en;
    logic [31:0] jmp_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ifu_valid;
    logic        idu_ready;
    logic [31:0] ifu_pc;
    logic [31:0] ifu_inst;
    logic        ifu_err;

    always #5 clk = ~clk;

    ifu_fetch_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RST_PC     (32'h8000_0000)
    ) dut (
        .i_sys_clk       (clk),
        .i_sys_rst_n     (rst_n),
        .i_exu_jmp_en    (jmp_en),
        .i_exu_jmp_pc    (jmp_pc),
        .o_mem_req_valid (req_valid),
        .i_mem_req_ready (req_ready),
        .o_mem_req_addr  (req_addr),
        .i_mem_rsp_valid (rsp_valid),
        .i_mem_rsp_data  (rsp_data),
        .i_mem_rsp_err   (rsp_err),
        .o_ifu_valid     (ifu_valid),
        .i_idu_ready     (idu_ready),
        .o_ifu_pc        (ifu_pc),
        .o_ifu_inst      (ifu_inst),
        .o_ifu_err       (ifu_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: fetch address, queue of in-flight fetches (live/killed),
    // and the word currently offered to the decoder.
    logic [31:0] m_pc;
    bit          inflight[$];
    bit          have_word;
    logic [31:0] w_inst;
    logic        w_err;
    bit          model_ok = 1'b0;
    logic [31:0] deliv_pc[$];
    logic [31:0] deliv_inst[$];

    always @(negedge clk) begin
        bit exp_req;
        bit live;
        if (model_ok) begin
            exp_req = (inflight.size() == 0) && !have_word;
            chk("mem_req_valid", req_valid, exp_req);
            chk("mem_req_addr",  req_addr,  m_pc);
            chk("ifu_valid",     ifu_valid, have_word && !jmp_en);
            chk("ifu_pc",        ifu_pc,    m_pc);
            chk("ifu_inst",      ifu_inst,  w_inst);
            chk("ifu_err",       ifu_err,   w_err);
            if (ifu_valid && idu_ready) begin
                deliv_pc.push_back(ifu_pc);
                deliv_inst.push_back(ifu_inst);
            end
        end
        if (!rst_n) begin
            m_pc = 32'h8000_0000;
            inflight.delete();
            have_word = 1'b0;
            w_inst = '0;
            w_err = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (have_word) begin
                if (jmp_en) begin
                    m_pc = jmp_pc;
                    have_word = 1'b0;
                end else if (idu_ready) begin
                    m_pc = m_pc + 32'd4;
                    have_word = 1'b0;
                end
            end else if (inflight.size() != 0) begin
                if (rsp_valid) begin
                    live = inflight.pop_front();
                    if (live && !jmp_en) begin
                        have_word = 1'b1;
                        w_inst = rsp_data;
                        w_err = rsp_err;
                    end
                end else if (jmp_en) begin
                    inflight[0] = 1'b0;
                end
                if (jmp_en) m_pc = jmp_pc;
            end else begin
                if (jmp_en) m_pc = jmp_pc;
                if (req_ready) inflight.push_back(!jmp_en);
            end
        end
    end

    // Memory responder: word = ~address, delivered rsp_lat cycles after acceptance.
    int unsigned rsp_lat  = 1;
    bit          err_next = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data;
    logic        pend_err;

    task automatic step();
        bit          fire;
        logic [31:0] a;
        #1;
        fire = req_valid && req_ready;
        a = req_addr;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data = pend_data;
                rsp_err = pend_err;
            end
        end
        if (fire) begin
            pend_cnt = int'(rsp_lat) - 1;
            pend_data = ~a;
            pend_err = err_next;
            if (pend_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data = pend_data;
                rsp_err = pend_err;
            end
        end
    endtask

    task automatic wait_ifu_valid(input string name);
        for (int k = 0; k < 20 && !ifu_valid; k++) step();
        chk(name, ifu_valid, 1'b1);
    endtask

    task automatic wait_req(input string name, output int unsigned stale_seen);
        stale_seen = 0;
        for (int k = 0; k < 20 && !req_valid; k++) begin
            if (ifu_valid) stale_seen++;
            step();
        end
        chk(name, req_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned stale;
        rst_n = 1'b0; jmp_en = 1'b0; jmp_pc = '0; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0; idu_ready = 1'b1;
        step(); step();
        chk("rst_req_valid", req_valid, 1'b1);
        chk("rst_addr",      req_addr,  32'h8000_0000);
        chk("rst_ifu_valid", ifu_valid, 1'b0);
        chk("rst_inst",      ifu_inst,  32'h0);
        rst_n = 1'b1;
        chk("first_req_addr", req_addr, 32'h8000_0000);

        // Three back-to-back fetches with single-cycle memory.
        deliv_pc.delete();
        deliv_inst.delete();
        repeat (9) step();
        chk("deliv_count", 64'(deliv_pc.size()), 64'd3);
        if (deliv_pc.size() >= 3) begin
            chk("deliv0_pc",   deliv_pc[0],   32'h8000_0000);
            chk("deliv0_inst", deliv_inst[0], 32'h7FFF_FFFF);
            chk("deliv1_pc",   deliv_pc[1],   32'h8000_0004);
            chk("deliv1_inst", deliv_inst[1], 32'h7FFF_FFFB);
            chk("deliv2_pc",   deliv_pc[2],   32'h8000_0008);
            chk("deliv2_inst", deliv_inst[2], 32'h7FFF_FFF7);
        end

        // Redirect while waiting; response lands two cycles later and is dropped.
        wait_req("wait_req_b", stale);
        rsp_lat = 3;
        step();
        jmp_en = 1'b1; jmp_pc = 32'h8000_0100;
        step();
        jmp_en = 1'b0; rsp_lat = 1;
        wait_req("wait_req_after_drop", stale);
        chk("drop_no_valid", 64'(stale), 64'd0);
        chk("redirect_addr", req_addr, 32'h8000_0100);

        // Redirect while holding an instruction: kill overrides IDU ready.
        wait_ifu_valid("wait_valid_c");
        jmp_en = 1'b1; jmp_pc = 32'h8000_0200; idu_ready = 1'b1;
        #1;
        chk("kill_valid", ifu_valid, 1'b0);
        step();
        jmp_en = 1'b0;
        chk("kill_req_valid", req_valid, 1'b1);
        chk("kill_req_addr",  req_addr,  32'h8000_0200);

        // Decoder stalls for five cycles.
        idu_ready = 1'b0;
        wait_ifu_valid("wait_valid_d");
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", ifu_valid, 1'b1);
            chk("stall_pc",    ifu_pc,    32'h8000_0200);
            chk("stall_inst",  ifu_inst,  32'h7FFF_FDFF);
            chk("stall_noreq", req_valid, 1'b0);
        end

        // Memory backpressure, then a faulting response.
        idu_ready = 1'b1; req_ready = 1'b0;
        step();
        idu_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", req_valid, 1'b1);
            chk("bp_addr",  req_addr,  32'h8000_0204);
            step();
        end
        req_ready = 1'b1; err_next = 1'b1;
        step();
        err_next = 1'b0;
        wait_ifu_valid("wait_valid_e");
        chk("fault_err",  ifu_err,  1'b1);
        chk("fault_pc",   ifu_pc,   32'h8000_0204);
        chk("fault_inst", ifu_inst, 32'h7FFF_FDFB);

        // PC wrap at the top of the address space.
        jmp_en = 1'b1; jmp_pc = 32'hFFFF_FFFC;
        step();
        jmp_en = 1'b0;
        wait_ifu_valid("wait_valid_f");
        chk("top_pc", ifu_pc, 32'hFFFF_FFFC);
        idu_ready = 1'b1;
        step();
        chk("wrap_req_valid", req_valid, 1'b1);
        chk("wrap_addr",      req_addr,  32'h0);

        // Reset while a fetch is outstanding; its late response must be ignored.
        rsp_lat = 3;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; req_ready = 1'b0; rsp_lat = 1;
        chk("rerst_req_valid", req_valid, 1'b1);
        chk("rerst_addr",      req_addr,  32'h8000_0000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("late_rsp_ignored", ifu_valid, 1'b0);
            chk("late_rsp_addr",    req_addr,  32'h8000_0000);
        end
        req_ready = 1'b1;
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
